// File: rtl/turn_controller_if.sv
// Key-event and move-issue bundle between the keypad/board side and turn_controller.
// master drives keys, board state and the tick; slave is the controller itself.
interface turn_controller_if #(
  parameter int BOARD_N = 3,
  parameter int KEY_W   = 4,
  parameter int LOC_W   = 4
) ();
  localparam int CELLS = BOARD_N * BOARD_N;

  logic                 tick;
  logic                 keyValid;
  logic [KEY_W-1:0]     keyCode;
  logic [2*CELLS-1:0]   board;
  logic                 gameEnd;
  logic                 placeValid;
  logic [LOC_W-1:0]     location;
  logic [1:0]           mark;
  logic                 whosTurn;
  logic                 reject;
  logic                 timeout;
  logic [3:0]           timeSec;
  logic [3:0]           timeTenth;

  modport master (
    output tick, keyValid, keyCode, board, gameEnd,
    input  placeValid, location, mark, whosTurn, reject, timeout, timeSec, timeTenth
  );

  modport slave (
    input  tick, keyValid, keyCode, board, gameEnd,
    output placeValid, location, mark, whosTurn, reject, timeout, timeSec, timeTenth
  );
endinterface

// File: rtl/turn_controller.sv
// Turn controller for the N x N mark-placement game: validates key events, issues moves,
// and runs the per-turn countdown when TURN_TIMER_EN is defined (default build: no timer).
module turn_controller #(
  parameter int BOARD_N    = 3,
  parameter int KEY_W      = 4,
  parameter int LOC_W      = 4,
  parameter int TURN_TICKS = 800,
  parameter int X_FIRST    = 0
) (
  input  logic             clk,
  input  logic             rst,
  turn_controller_if.slave bus
);
  localparam int CELLS = BOARD_N * BOARD_N;

  typedef enum logic {PLAY, FROZEN} state_e;

  state_e           state_q;
  logic [LOC_W-1:0] location_q;
  logic [1:0]       mark_q;
  logic             turn_q;
  logic             place_q;
  logic             reject_q;

  logic active_w;
  logic in_range_w;
  logic empty_w;
  logic accept_w;
  logic refuse_w;
  logic expire_w;

  // The exit edge from FROZEN only re-arms the controller; inputs that cycle are dropped.
  always_comb begin
    active_w   = (state_q == PLAY) && !bus.gameEnd;
    in_range_w = int'(bus.keyCode) < CELLS;
    empty_w    = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (int'(bus.keyCode) == i) empty_w = (bus.board[2*i +: 2] == 2'b00);
    end
    accept_w = active_w && bus.keyValid && in_range_w && empty_w;
    refuse_w = active_w && bus.keyValid && !accept_w;
  end

`ifdef TURN_TIMER_EN
  localparam int CNT_W = $clog2(TURN_TICKS + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TURN_TICKS);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic [3:0]       sec_w;
  logic [3:0]       tenth_w;

  // An accepted key on the expiring tick wins: no timeout, plain reload.
  assign expire_w = active_w && bus.tick && !accept_w && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= RELOAD;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire_w;
      if (accept_w || expire_w) cnt_q <= RELOAD;
      else if (active_w && bus.tick) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    int cnt_int;
    cnt_int = int'(cnt_q);
    sec_w   = 4'(cnt_int / 100);
    tenth_w = 4'((cnt_int / 10) % 10);
  end

  assign bus.timeout   = timeout_q;
  assign bus.timeSec   = sec_w;
  assign bus.timeTenth = tenth_w;
`else
  logic unused_tick_w;

  assign unused_tick_w = bus.tick;
  assign expire_w      = 1'b0;
  assign bus.timeout   = 1'b0;
  assign bus.timeSec   = 4'd0;
  assign bus.timeTenth = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PLAY;
      location_q <= '0;
      mark_q     <= 2'b00;
      turn_q     <= (X_FIRST != 0);
      place_q    <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      place_q  <= accept_w;
      reject_q <= refuse_w;
      state_q  <= bus.gameEnd ? FROZEN : PLAY;
      if (accept_w) begin
        location_q <= LOC_W'(bus.keyCode);
        mark_q     <= turn_q ? 2'b10 : 2'b01;
        turn_q     <= ~turn_q;
      end else if (expire_w) begin
        turn_q <= ~turn_q;
      end
    end
  end

  assign bus.placeValid = place_q;
  assign bus.location   = location_q;
  assign bus.mark       = mark_q;
  assign bus.whosTurn   = turn_q;
  assign bus.reject     = reject_q;
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: 3x3 instance for play/timer/freeze, 4x4 for the top cell.
module tb_turn_controller;
`ifdef TURN_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  turn_controller_if #(.BOARD_N(3), .KEY_W(4), .LOC_W(4)) bus3 ();
  turn_controller_if #(.BOARD_N(4), .KEY_W(4), .LOC_W(4)) bus4 ();

  turn_controller #(.BOARD_N(3), .KEY_W(4), .LOC_W(4), .TURN_TICKS(800), .X_FIRST(0))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));
  turn_controller #(.BOARD_N(4), .KEY_W(4), .LOC_W(4), .TURN_TICKS(800), .X_FIRST(0))
    dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    bus3.tick = 1'b1;
    repeat (n) cyc();
    bus3.tick = 1'b0;
  endtask

  task automatic key3(input logic [3:0] code, input logic [17:0] brd);
    bus3.keyValid = 1'b1;
    bus3.keyCode  = code;
    bus3.board    = brd;
  endtask

  task automatic idle3();
    bus3.keyValid = 1'b0;
    bus3.keyCode  = '0;
    bus3.tick     = 1'b0;
  endtask

  logic [1:0] mark6;
  logic       t5;

  initial begin
    bus3.tick = 0; bus3.keyValid = 0; bus3.keyCode = '0; bus3.board = '0; bus3.gameEnd = 0;
    bus4.tick = 0; bus4.keyValid = 0; bus4.keyCode = '0; bus4.board = '0; bus4.gameEnd = 0;

    // reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_turn", bus3.whosTurn, 0);
    chk("rst_mark", bus3.mark, 0);
    chk("rst_loc", bus3.location, 0);
    chk("rst_place", bus3.placeValid, 0);
    chk("rst_reject", bus3.reject, 0);
    chk("rst_timeout", bus3.timeout, 0);
    chk("rst_sec", bus3.timeSec, TMR ? 8 : 0);
    chk("rst_tenth", bus3.timeTenth, 0);

    // accepted move on an empty board
    key3(4'd4, 18'h0);
    cyc();
    idle3();
    chk("acc_place", bus3.placeValid, 1);
    chk("acc_loc", bus3.location, 4);
    chk("acc_mark", bus3.mark, 2'b01);
    chk("acc_turn", bus3.whosTurn, 1);
    chk("acc_sec", bus3.timeSec, TMR ? 8 : 0);
    cyc();
    chk("acc_strobe_drop", bus3.placeValid, 0);

    // occupied cell and out-of-range keys
    key3(4'd4, 18'h200);
    cyc();
    idle3();
    chk("occ_reject", bus3.reject, 1);
    chk("occ_place", bus3.placeValid, 0);
    chk("occ_mark", bus3.mark, 2'b01);
    chk("occ_turn", bus3.whosTurn, 1);
    key3(4'd9, 18'h0);
    cyc();
    idle3();
    chk("rng9_reject", bus3.reject, 1);
    chk("rng9_loc", bus3.location, 4);
    key3(4'd15, 18'h0);
    cyc();
    idle3();
    chk("rng15_reject", bus3.reject, 1);
    chk("rng15_turn", bus3.whosTurn, 1);
    cyc();
    chk("rej_strobe_drop", bus3.reject, 0);

    // countdown and expiry
    ticks(150);
    chk("t150_sec", bus3.timeSec, TMR ? 6 : 0);
    chk("t150_tenth", bus3.timeTenth, TMR ? 5 : 0);
    ticks(649);
    chk("t799_sec", bus3.timeSec, 0);
    chk("t799_tenth", bus3.timeTenth, 0);
    chk("t799_timeout", bus3.timeout, 0);
    ticks(1);
    chk("exp_timeout", bus3.timeout, TMR ? 1 : 0);
    chk("exp_turn", bus3.whosTurn, TMR ? 0 : 1);
    chk("exp_sec", bus3.timeSec, TMR ? 8 : 0);
    chk("exp_tenth", bus3.timeTenth, 0);
    cyc();
    chk("exp_strobe_drop", bus3.timeout, 0);

    // accepted key on the expiring tick
    t5 = TMR ? 1'b0 : 1'b1;
    mark6 = t5 ? 2'b10 : 2'b01;
    ticks(799);
    key3(4'd0, 18'h0);
    bus3.tick = 1'b1;
    cyc();
    idle3();
    chk("race_place", bus3.placeValid, 1);
    chk("race_timeout", bus3.timeout, 0);
    chk("race_loc", bus3.location, 0);
    chk("race_mark", bus3.mark, mark6);
    chk("race_turn", bus3.whosTurn, !t5);
    chk("race_sec", bus3.timeSec, TMR ? 8 : 0);
    chk("race_tenth", bus3.timeTenth, 0);

    // rejected key on the expiring tick
    ticks(799);
    key3(4'd4, 18'h200);
    bus3.tick = 1'b1;
    cyc();
    idle3();
    chk("rjx_reject", bus3.reject, 1);
    chk("rjx_timeout", bus3.timeout, TMR ? 1 : 0);
    chk("rjx_place", bus3.placeValid, 0);
    chk("rjx_turn", bus3.whosTurn, 0);
    chk("rjx_mark", bus3.mark, mark6);

    // freeze at 3.2
    ticks(480);
    chk("pre_frz_sec", bus3.timeSec, TMR ? 3 : 0);
    chk("pre_frz_tenth", bus3.timeTenth, TMR ? 2 : 0);
    bus3.gameEnd = 1'b1;
    key3(4'd0, 18'h0);
    bus3.tick = 1'b1;
    repeat (50) begin
      cyc();
      chk("frz_strobes", {bus3.placeValid, bus3.reject, bus3.timeout}, 0);
    end
    idle3();
    chk("frz_sec", bus3.timeSec, TMR ? 3 : 0);
    chk("frz_tenth", bus3.timeTenth, TMR ? 2 : 0);
    chk("frz_turn", bus3.whosTurn, 0);
    chk("frz_mark", bus3.mark, mark6);
    bus3.gameEnd = 1'b0;
    cyc();
    ticks(1);
    chk("thaw_sec", bus3.timeSec, TMR ? 3 : 0);
    chk("thaw_tenth", bus3.timeTenth, TMR ? 1 : 0);

    // 4x4 board: cell 15 is legal
    bus4.keyValid = 1'b1;
    bus4.keyCode  = 4'd15;
    bus4.board    = '0;
    cyc();
    bus4.keyValid = 1'b0;
    chk("n4_place", bus4.placeValid, 1);
    chk("n4_loc", bus4.location, 15);
    chk("n4_mark", bus4.mark, 2'b01);
    chk("n4_turn", bus4.whosTurn, 1);

    // reset dominates a pending key
    key3(4'd1, 18'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle3();
    chk("rstkey_place", bus3.placeValid, 0);
    chk("rstkey_loc", bus3.location, 0);
    chk("rstkey_turn", bus3.whosTurn, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
